// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and the IF/ID pipeline register.
// Optional performance counters are enabled with the FETCH_PERF_CNT_EN macro.
module fetch_unit #(
  parameter int              AW        = 8,
  parameter int              IW        = 16,
  parameter logic [AW-1:0]   RESET_PC  = AW'(8'h00),
  parameter logic [IW-1:0]   HALT_WORD = IW'(16'h0001)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          stall,
  input  logic          flush,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [AW-1:0] imem_addr,
  output logic          imem_rd,
  input  logic [IW-1:0] imem_data,
  output logic [IW-1:0] ifid_instr,
  output logic [AW-1:0] ifid_pc,
  output logic [AW-1:0] ifid_pc_plus1,
  output logic          ifid_valid,
  output logic          halted,
  output logic [15:0]   perf_fetch_cnt,
  output logic [15:0]   perf_stall_cnt
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] pc_next;
  logic          load;
  logic          halt_hit;

  assign pc_next   = pc_q + AW'(1);
  // An IF/ID load happens only in RUN when neither redirect nor stall takes priority.
  assign load      = (state_q == RUN) && !redirect && !stall;
  assign halt_hit  = load && !flush && (imem_data == HALT_WORD);

  assign imem_addr = pc_q;
  assign imem_rd   = (state_q == RUN);
  assign halted    = (state_q == HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: defaulting first guarantees every path assigns state_d, so no latch.
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (halt_hit) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      ifid_instr    <= '0;
      ifid_pc       <= '0;
      ifid_pc_plus1 <= '0;
      ifid_valid    <= 1'b0;
    end else if (state_q == RUN) begin
      if (redirect) begin
        pc_q       <= redirect_pc;
        ifid_valid <= 1'b0;
      end else if (stall) begin
        if (flush) ifid_valid <= 1'b0;
      end else begin
        ifid_instr    <= imem_data;
        ifid_pc       <= pc_q;
        ifid_pc_plus1 <= pc_next;
        ifid_valid    <= !flush;
        // The PC parks on the halt word's own address.
        if (!halt_hit) pc_q <= pc_next;
      end
    end else begin
      ifid_valid <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q, stall_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      if (load && !flush && fetch_cnt_q != 16'hFFFF)
        fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (state_q == RUN && stall && !redirect && stall_cnt_q != 16'hFFFF)
        stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign perf_fetch_cnt = fetch_cnt_q;
  assign perf_stall_cnt = stall_cnt_q;
`else
  assign perf_fetch_cnt = 16'h0000;
  assign perf_stall_cnt = 16'h0000;
`endif

endmodule
